// File: rtl/wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter_pkg
// Purpose  : Shared widths, bus types and starvation-FSM state encodings for
//            the writeback arbiter and its LSU result FIFO.
// Contents : REG_ADDR_W / INST_W / REG_NUM widths, ZERO_WORD, ENABLE/DISABLE,
//            reg_addr_t / inst_t / regnum_t bus types, wb_state_e encodings.
// Revision : 1.0 - initial release
// ============================================================================
package wb_arbiter_pkg;

    localparam int REG_ADDR_W   = 5;
    localparam int INST_W       = 32;
    localparam int REG_NUM      = 32;
    localparam int STARVE_CNT_W = 4;

    localparam logic [INST_W-1:0] ZERO_WORD = '0;
    localparam logic              ENABLE    = 1'b1;
    localparam logic              DISABLE   = 1'b0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [INST_W-1:0]     inst_t;
    typedef logic [REG_NUM-1:0]    regnum_t;

    // Starvation FSM encodings
    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_WAIT = 2'd1,
        WB_HOLD = 2'd2
    } wb_state_e;

endpackage : wb_arbiter_pkg
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo
// Purpose  : Circular buffer holding LSU results while the ALU owns the
//            register-file write port. Exposes per-entry valid/rd so the
//            parent can build the pending-register mask.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            push/push_rd/_data  - enqueue at tail
//            pop                 - dequeue head
//            head_rd/head_data   - current head entry
//            head_ptr            - slot index of the head
//            count/full/empty    - occupancy
//            entry_valid/entry_rd- per-slot occupancy and destination
// Revision : 1.0 - initial release
// ============================================================================
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  reg_addr_t              push_rd,
    input  inst_t                  push_data,
    input  logic                   pop,
    output reg_addr_t              head_rd,
    output inst_t                  head_data,
    output logic [PTR_W-1:0]       head_ptr,
    output logic [CNT_W-1:0]       count,
    output logic                   full,
    output logic                   empty,
    output logic [DEPTH-1:0]       entry_valid,
    output reg_addr_t [DEPTH-1:0]  entry_rd
);

    reg_addr_t [DEPTH-1:0] r_rd;
    inst_t                 r_data [DEPTH];
    logic [DEPTH-1:0]      r_valid;
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_W-1:0]      r_count;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            // Clear on pop before set on push; the two never target the same
            // slot because the parent never pushes into a full buffer.
            if (pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= ptr_inc(r_head);
            end
            if (push) begin
                r_rd[r_tail]    <= push_rd;
                r_data[r_tail]  <= push_data;
                r_valid[r_tail] <= 1'b1;
                r_tail          <= ptr_inc(r_tail);
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head_rd     = r_rd[r_head];
    assign head_data   = r_data[r_head];
    assign head_ptr    = r_head;
    assign count       = r_count;
    assign full        = (r_count == CNT_W'(DEPTH));
    assign empty       = (r_count == '0);
    assign entry_valid = r_valid;
    assign entry_rd    = r_rd;

endmodule : wb_fifo
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Purpose  : Merges the single-cycle ALU result stream and the handshaked
//            LSU result stream onto one register-file write port. LSU
//            results wait in a FIFO while the ALU owns the port; a
//            starvation FSM requests an issue hold when the FIFO head waits
//            too long.
// Ports    : clk, rst                     - clock, sync active-high reset
//            alu_valid/alu_rd/alu_data    - ALU result (no back-pressure)
//            lsu_valid/lsu_ready/lsu_rd/lsu_data - LSU result handshake
//            rd_waddr/rd_wdata/wen        - registered write port
//            pend_mask                    - registers targeted by FIFO entries
//            alu_hold                     - registered issue hold request
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      alu_valid,
    input  reg_addr_t alu_rd,
    input  inst_t     alu_data,
    input  logic      lsu_valid,
    output logic      lsu_ready,
    input  reg_addr_t lsu_rd,
    input  inst_t     lsu_data,
    output reg_addr_t rd_waddr,
    output inst_t     rd_wdata,
    output logic      wen,
    output regnum_t   pend_mask,
    output logic      alu_hold
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [STARVE_CNT_W-1:0] c_limit = STARVE_CNT_W'(STARVE_LIMIT);

    logic                       w_alu_wr;
    logic                       w_accept;
    logic                       w_lsu_wr;
    logic                       w_pop;
    logic                       w_push;
    logic                       w_bypass;
    logic                       w_blocked;
    logic                       w_empty_after;
    reg_addr_t                  w_head_rd;
    inst_t                      w_head_data;
    logic [PTR_W-1:0]           w_head_ptr;
    logic [CNT_W-1:0]           w_count;
    logic                       w_full;
    logic                       w_empty;
    logic [FIFO_DEPTH-1:0]      w_entry_valid;
    reg_addr_t [FIFO_DEPTH-1:0] w_entry_rd;
    logic [STARVE_CNT_W-1:0]    w_cnt_next;

    wb_state_e                  r_state;
    logic [STARVE_CNT_W-1:0]    r_cnt;
    logic                       r_hold;
    logic                       r_wen;
    reg_addr_t                  r_waddr;
    inst_t                      r_wdata;

    // Writes to x0 never occupy the port.
    assign w_alu_wr  = alu_valid && (alu_rd != '0);
    assign w_accept  = lsu_valid && lsu_ready;
    assign w_lsu_wr  = w_accept && (lsu_rd != '0);

    assign w_pop     = !w_alu_wr && !w_empty;
    assign w_bypass  = !w_alu_wr && w_empty && w_lsu_wr;
    assign w_push    = w_lsu_wr && !w_bypass;
    assign w_blocked = !w_empty && !w_pop;

    assign w_empty_after = (w_count == CNT_W'(1)) && !w_push;
    assign w_cnt_next    = r_cnt + 1'b1;

    // Ready comes from the registered count only, so a full FIFO stays
    // closed for the cycle of a dequeue.
    assign lsu_ready = !w_full;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (w_push),
        .push_rd     (lsu_rd),
        .push_data   (lsu_data),
        .pop         (w_pop),
        .head_rd     (w_head_rd),
        .head_data   (w_head_data),
        .head_ptr    (w_head_ptr),
        .count       (w_count),
        .full        (w_full),
        .empty       (w_empty),
        .entry_valid (w_entry_valid),
        .entry_rd    (w_entry_rd)
    );

    // The head being written this cycle no longer counts as pending.
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (w_entry_valid[i] && !(w_pop && (w_head_ptr == PTR_W'(i)))) begin
                pend_mask[w_entry_rd[i]] = 1'b1;
            end
        end
        pend_mask[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wen   <= DISABLE;
            r_waddr <= '0;
            r_wdata <= ZERO_WORD;
        end else begin
            r_wen <= w_alu_wr || w_pop || w_bypass;
            if (w_alu_wr) begin
                r_waddr <= alu_rd;
                r_wdata <= alu_data;
            end else if (w_pop) begin
                r_waddr <= w_head_rd;
                r_wdata <= w_head_data;
            end else if (w_bypass) begin
                r_waddr <= lsu_rd;
                r_wdata <= lsu_data;
            end
        end
    end

    // Starvation FSM: r_cnt counts consecutive cycles the head was blocked.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= WB_IDLE;
            r_cnt   <= '0;
            r_hold  <= DISABLE;
        end else begin
            case (r_state)
                WB_IDLE, WB_WAIT: begin
                    if (w_pop) begin
                        r_cnt   <= '0;
                        r_state <= w_empty_after ? WB_IDLE : WB_WAIT;
                    end else if (w_blocked) begin
                        r_cnt <= w_cnt_next;
                        if (w_cnt_next >= c_limit) begin
                            r_state <= WB_HOLD;
                            r_hold  <= ENABLE;
                        end else begin
                            r_state <= WB_WAIT;
                        end
                    end
                end
                WB_HOLD: begin
                    if (w_pop) begin
                        r_cnt   <= '0;
                        r_hold  <= DISABLE;
                        r_state <= w_empty_after ? WB_IDLE : WB_WAIT;
                    end
                end
                default: begin
                    r_state <= WB_IDLE;
                    r_cnt   <= '0;
                    r_hold  <= DISABLE;
                end
            endcase
        end
    end

    assign wen      = r_wen;
    assign rd_waddr = r_waddr;
    assign rd_wdata = r_wdata;
    assign alu_hold = r_hold;

endmodule : wb_arbiter
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter
// Purpose  : Self-checking bench for wb_arbiter. A queue-based reference
//            model tracks buffered LSU results, expected port writes, the
//            pending mask and the starvation hold; directed scenarios are
//            followed by a randomized traffic phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic [4:0]  rd_waddr;
    logic [31:0] rd_wdata;
    logic        wen;
    logic [31:0] pend_mask;
    logic        alu_hold;

    // Reference model state
    res_t        m_q[$];        // LSU results waiting for the port
    res_t        lsu_pend[$];   // results the LSU still has to offer
    logic        m_wen;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        m_hold;
    int          m_run;         // consecutive cycles the buffered head waited
    logic        m_after_rst;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_arbiter #(
        .FIFO_DEPTH   (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .rd_waddr  (rd_waddr),
        .rd_wdata  (rd_wdata),
        .wen       (wen),
        .pend_mask (pend_mask),
        .alu_hold  (alu_hold)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        alu_valid = 1'b0;
        alu_rd    = '0;
        alu_data  = '0;
        lsu_valid = 1'b0;
        lsu_rd    = '0;
        lsu_data  = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_q.delete();
        lsu_pend.delete();
        m_wen       = 1'b0;
        m_addr      = '0;
        m_data      = '0;
        m_hold      = 1'b0;
        m_run       = 0;
        m_after_rst = 1'b1;
    endtask

    // One clock cycle: drive ALU input and the oldest outstanding LSU offer,
    // check the DUT against the model, then advance the model.
    task automatic step(input logic av, input logic [4:0] ar, input logic [31:0] ad);
        res_t        off;
        logic        lv, alu_wr, acc, lwr, pop, byp;
        int          qs;
        logic [31:0] mask;
        @(negedge clk);
        lv  = (lsu_pend.size() > 0);
        off = lv ? lsu_pend[0] : '0;
        alu_valid = av;
        alu_rd    = ar;
        alu_data  = ad;
        lsu_valid = lv;
        lsu_rd    = off.rd;
        lsu_data  = off.data;
        #1;
        qs     = m_q.size();
        alu_wr = av && (ar != 5'd0);
        acc    = lv && (qs < DEPTH);
        lwr    = acc && (off.rd != 5'd0);
        pop    = !alu_wr && (qs > 0);
        byp    = !alu_wr && (qs == 0) && lwr;
        mask   = '0;
        for (int i = (pop ? 1 : 0); i < qs; i++) mask[m_q[i].rd] = 1'b1;
        mask[0] = 1'b0;

        chk("wen", 32'(wen), 32'(m_wen));
        if (m_wen || m_after_rst) begin
            chk("rd_waddr", 32'(rd_waddr), 32'(m_addr));
            chk("rd_wdata", rd_wdata, m_data);
        end
        chk("lsu_ready", 32'(lsu_ready), 32'(qs < DEPTH));
        chk("pend_mask", pend_mask, mask);
        chk("alu_hold", 32'(alu_hold), 32'(m_hold));

        m_after_rst = 1'b0;
        m_wen = alu_wr || pop || byp;
        if (alu_wr) begin
            m_addr = ar;
            m_data = ad;
        end else if (pop) begin
            m_addr = m_q[0].rd;
            m_data = m_q[0].data;
        end else if (byp) begin
            m_addr = off.rd;
            m_data = off.data;
        end
        if (acc) void'(lsu_pend.pop_front());
        if (pop) void'(m_q.pop_front());
        if (lwr && !byp) m_q.push_back(off);
        if (pop) m_run = 0;
        else if (qs > 0) m_run++;
        m_hold = (m_run >= LIMIT);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        do_reset();

        // Lone LSU result bypasses the buffer
        lsu_pend.push_back('{rd: 5'd5, data: 32'h11});
        idle(3);

        // ALU x1..x3 while LSU offers x7
        lsu_pend.push_back('{rd: 5'd7, data: 32'hAA});
        step(1'b1, 5'd1, 32'h101);
        step(1'b1, 5'd2, 32'h102);
        step(1'b1, 5'd3, 32'h103);
        idle(3);

        // Back-pressure: three LSU results against continuous ALU traffic
        for (int k = 0; k < 3; k++) lsu_pend.push_back('{rd: 5'(10 + k), data: 32'hB0 + 32'(k)});
        for (int k = 0; k < 3; k++) step(1'b1, 5'(20 + k), 32'hC0 + 32'(k));
        idle(6);

        // Starvation: one buffered entry, ALU backs off once hold is seen
        lsu_pend.push_back('{rd: 5'd12, data: 32'h1234});
        step(1'b1, 5'd4, 32'h44);
        for (int k = 0; k < 8; k++) step(!m_hold, 5'd6, 32'h600 + 32'(k));
        idle(2);

        // ALU rd=0 leaves the port to the buffered x9; LSU rd=0 is dropped
        lsu_pend.push_back('{rd: 5'd9, data: 32'h99});
        step(1'b1, 5'd3, 32'h33);
        step(1'b1, 5'd0, 32'hDEAD);
        idle(2);
        lsu_pend.push_back('{rd: 5'd0, data: 32'h55});
        idle(3);

        // Reset with two entries pending drops them
        lsu_pend.push_back('{rd: 5'd14, data: 32'hE1});
        lsu_pend.push_back('{rd: 5'd15, data: 32'hE2});
        step(1'b1, 5'd1, 32'h1);
        step(1'b1, 5'd2, 32'h2);
        do_reset();
        idle(3);

        // Randomized traffic, ALU sometimes ignoring the hold
        for (int k = 0; k < 400; k++) begin
            logic       av;
            logic [4:0] ar;
            if (lsu_pend.size() == 0 && $urandom_range(0, 2) == 0)
                lsu_pend.push_back('{rd: 5'($urandom_range(0, 7)), data: $urandom});
            av = ($urandom_range(0, 3) != 0);
            if (k >= 200 && m_hold) av = 1'b0;
            ar = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            step(av, ar, $urandom);
        end
        idle(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_wb_arbiter
`default_nettype wire

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter between the execute/memory pipeline and the register file write port. It merges two result sources onto the single write port (`rd_waddr`/`rd_wdata`/`wen`):
- a single-cycle ALU result stream with no back-pressure;
- a multi-cycle LSU result stream with a valid/ready handshake.

LSU results are held in a small FIFO while the ALU owns the port. The block exports a pending-register mask for the issue scoreboard and raises an upstream hold request when LSU results starve.

## Interface
Parameters:
- `FIFO_DEPTH`, 2: LSU result buffer entries; legal range 2..8.
- `STARVE_LIMIT`, 4: consecutive cycles the FIFO head may wait before `alu_hold` asserts; legal range 1..15.

Ports:
- `clk`  in  1  core clock; one clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `alu_valid`  in  1  ALU result present this cycle.
- `alu_rd`  in  `RegAddrBus` (5)  ALU destination register.
- `alu_data`  in  `InstBus` (32)  ALU result.
- `lsu_valid`  in  1  LSU result offered.
- `lsu_ready`  out  1  LSU result accepted when `lsu_valid & lsu_ready`.
- `lsu_rd`  in  5  LSU destination register.
- `lsu_data`  in  32  LSU result.
- `rd_waddr`  out  5  register file write address (registered).
- `rd_wdata`  out  32  register file write data (registered).
- `wen`  out  1  register file write enable (registered).
- `pend_mask`  out  `Regnum` (32)  bit r set while a FIFO entry targets xr.
- `alu_hold`  out  1  request to the issue stage to suppress ALU results next cycle.

## Operation
- ALU result is writable when `alu_valid` is high and `alu_rd` is not 0; an ALU result with rd = 0 is ignored and does not occupy the port.
- LSU result with rd = 0 is accepted (handshake completes) and discarded; it is never enqueued.
- Port selection each cycle, in priority order:
  1. A writable ALU result.
  2. Otherwise the FIFO head.
  3. Otherwise a newly accepted LSU result, bypassing the FIFO when the FIFO is empty.
  4. Otherwise the port is idle.
- An accepted LSU result that is not bypassed is enqueued at the tail.
- Simultaneous dequeue and enqueue in one cycle is legal; the count is unchanged.
- `lsu_ready` = (count < `FIFO_DEPTH`), evaluated from the registered count only. A same-cycle dequeue does not raise ready.
- FIFO is a circular buffer with head/tail pointers wrapping at `FIFO_DEPTH` and a count register. Writes are in acceptance order; there is no reordering.
- `pend_mask` is combinational from the valid FIFO entries. It excludes the entry being written this cycle once that entry is dequeued. Bit 0 is always 0.
- Starvation FSM, states IDLE, WAIT, HOLD:
  - IDLE → WAIT when the FIFO is non-empty and the head is not dequeued.
  - In WAIT, a counter increments each cycle the head is blocked and clears on any dequeue. Dequeue with the FIFO becoming empty → IDLE. Counter reaches `STARVE_LIMIT` → HOLD.
  - HOLD drives `alu_hold` = 1 and returns to IDLE or WAIT (by FIFO occupancy) on the first dequeue.
- An ALU result that arrives while `alu_hold` is high still wins the port; the issue stage is responsible for honouring the hold.
- WAW ordering between ALU and pending LSU results is the issue stage's duty, using `pend_mask`.

## Timing
- Reset values: `wen` = 0, `rd_waddr` = 0, `rd_wdata` = 0, `lsu_ready` = 1, `pend_mask` = 0, `alu_hold` = 0. FIFO is empty, FSM is in IDLE, counter is 0.
- Reset mid-operation drops all FIFO contents without writing them.
- Latency is 1 cycle for every source: a result selected in cycle N appears on `rd_*`/`wen` in cycle N+1 for exactly one cycle.
- An LSU result enqueued in cycle N is eligible for dequeue in cycle N+1 at the earliest.
- `alu_hold` is registered. It asserts in the cycle after the counter reaches `STARVE_LIMIT` and deasserts in the cycle after the dequeue.
- Full boundary: with count = `FIFO_DEPTH`, `lsu_ready` stays 0 for that cycle even if a dequeue occurs. Ready returns the next cycle.

## Structure
- `defines.v` supplies `RegAddrBus`, `InstBus`, `Regnum`, `ZeroWord`, `Enable`/`Disable`.
- Add the FSM state encodings `WB_IDLE`/`WB_WAIT`/`WB_HOLD` as defines there.
- One sub-module: `wb_fifo`, a parameterised FIFO with depth, push/pop, count and full/empty, plus per-entry valid/rd outputs for the mask.
- Arbitration, the FSM and the output registers live in `wb_arbiter`.

## Test plan
- Reset, then LSU x5 = 0x11 with no ALU traffic → `wen` = 1, `rd_waddr` = 5, `rd_wdata` = 0x11 one cycle later; `pend_mask` stays 0.
- ALU writes x1..x3 on 3 consecutive cycles while LSU offers x7 = 0xAA:
  - LSU is enqueued; `pend_mask[7]` = 1;
  - the three ALU writes appear first, then x7 = 0xAA in the 4th output cycle;
  - `pend_mask[7]` clears after the dequeue.
- Continuous ALU traffic with 3 LSU results, `FIFO_DEPTH` = 2 → `lsu_ready` drops after 2 accepts; the third result waits until the cycle after the first dequeue.
- Continuous ALU traffic, 1 FIFO entry, `STARVE_LIMIT` = 4 → `alu_hold` rises after 4 blocked cycles; ALU idles; the entry is written; `alu_hold` falls the next cycle.
- ALU rd = 0 with `alu_valid` while the FIFO holds x9 → x9 is written that cycle; no write to x0 ever appears on `wen`. LSU rd = 0 is accepted and produces no write.
- `rst` pulsed with 2 FIFO entries pending → no further writes; `lsu_ready` = 1 and `pend_mask` = 0 on the cycle after reset.
